// File: rtl/mem_pkg.sv
// Shared definitions for the IF/LS main-memory arbiter.
package mem_pkg;

  localparam int unsigned WORD_SIZE   = 32;
  localparam int unsigned MEMORY_BITS = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between IF and LS requesters.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin on collisions; otherwise LS has fixed priority.
module mem_arb_pick
  import mem_pkg::*;
(
  input  logic if_req,
  input  logic ls_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic last_ls,
`endif
  output logic win_ls,
  output logic any
);

  always_comb begin
    any = if_req | ls_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a collision the requester not granted last time wins.
    if (if_req && ls_req)
      win_ls = (last_ls == GNT_LS) ? GNT_IF : GNT_LS;
    else
      win_ls = ls_req ? GNT_LS : GNT_IF;
`else
    win_ls = ls_req ? GNT_LS : GNT_IF;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port main memory between IF and LS: IDLE -> ACCESS -> RESP.
// Build option: MEM_ARB_ROUND_ROBIN_EN enables round-robin arbitration on collisions.
module mem_arbiter #(
  parameter int unsigned WORD_SIZE   = mem_pkg::WORD_SIZE,
  parameter int unsigned MEMORY_BITS = mem_pkg::MEMORY_BITS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_req,
  input  logic [MEMORY_BITS-1:0] if_addr,
  output logic                   if_done,
  output logic [WORD_SIZE-1:0]   if_rdata,
  input  logic                   ls_req,
  input  logic                   ls_we,
  input  logic [MEMORY_BITS-1:0] ls_addr,
  input  logic [WORD_SIZE-1:0]   ls_wdata,
  output logic                   ls_done,
  output logic [WORD_SIZE-1:0]   ls_rdata,
  output logic [MEMORY_BITS-1:0] mem_address,
  output logic                   mem_write,
  output logic                   mem_read,
  output logic [WORD_SIZE-1:0]   mem_wdata,
  input  logic [WORD_SIZE-1:0]   mem_rdata,
  output logic                   busy,
  output logic                   grant_ls
);

  import mem_pkg::*;

  state_t state;
  logic   win_ls;
  logic   any;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_ls;
`endif

  mem_arb_pick u_pick (
    .if_req  (if_req),
    .ls_req  (ls_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_ls (last_ls),
`endif
    .win_ls  (win_ls),
    .any     (any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      if_done     <= 1'b0;
      ls_done     <= 1'b0;
      if_rdata    <= '0;
      ls_rdata    <= '0;
      mem_address <= '0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      grant_ls    <= GNT_IF;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_ls     <= GNT_IF;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if_done <= 1'b0;
          ls_done <= 1'b0;
          if (any) begin
            state    <= ST_ACCESS;
            busy     <= 1'b1;
            grant_ls <= win_ls;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_ls  <= win_ls;
`endif
            if (win_ls == GNT_LS) begin
              mem_address <= ls_addr;
              mem_write   <= ls_we;
              mem_read    <= ~ls_we;
              // Write data only tracks LS writes; it holds across reads.
              if (ls_we)
                mem_wdata <= ls_wdata;
            end else begin
              mem_address <= if_addr;
              mem_write   <= 1'b0;
              mem_read    <= 1'b1;
            end
          end else begin
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
          end
        end
        ST_ACCESS: begin
          // Memory updated mem_rdata at the mid-cycle negedge; capture it now.
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          state     <= ST_RESP;
          if (grant_ls == GNT_LS) begin
            ls_done <= 1'b1;
            if (mem_read)
              ls_rdata <= mem_rdata;
          end else begin
            if_done  <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        ST_RESP: begin
          if_done <= 1'b0;
          ls_done <= 1'b0;
          busy    <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          if_done   <= 1'b0;
          ls_done   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
